// File: rtl/rtc_wb_slave_pkg.sv
// Shared definitions for the RTC Wishbone slave: register map, STATUS bits,
// FSM encoding and the BCD field checker used for set-time validation.
package rtc_pkg;

  localparam logic [1:0] ADR_TIME   = 2'd0;
  localparam logic [1:0] ADR_ALARM  = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;

  localparam int ST_PEND = 0;
  localparam int ST_WERR = 1;
  localparam int ST_AEN  = 2;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_STABLE = 2'd1,
    S_ACK         = 2'd2
  } state_t;

  // Both digits must be decimal and the whole field must not exceed limit.
  function automatic logic bcd_valid(input logic [7:0] field, input logic [7:0] limit);
    return (field[7:4] <= 4'd9) && (field[3:0] <= 4'd9) && (field <= limit);
  endfunction

endpackage

// File: rtl/rtc_wb_slave_if.sv
// Classic Wishbone slave port of the RTC; names follow the slave's point of view.
interface rtc_wb_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i, input  dat_o, ack_o);
endinterface

// File: rtl/rtc_wb_slave.sv
// Wishbone front end for the BCD time counters: coherent time reads, validated
// set-time loads, alarm register and alarm interrupt.
module rtc_wb_slave
  import rtc_pkg::*;
#(
  parameter int         SETTLE   = 2,
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic        clk_i,
  input  logic        rst_i,
  rtc_wb_if.slave     wb,
  input  logic [7:0]  sec_i,
  input  logic [7:0]  min_i,
  input  logic [7:0]  hour_i,
  input  logic        tick_i,
  output logic        load_o,
  output logic [23:0] load_dat_o,
  output logic        irq_o
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_t      r_state;
  logic [SW-1:0] r_settle;
  logic [31:0] r_dat;
  logic        r_ack;
  logic        r_load;
  logic        r_load_pend;
  logic [23:0] r_load_dat;
  logic [23:0] r_alarm;
  logic        r_aen;
  logic        r_pend;
  logic        r_werr;
  logic        r_prev_match;
  logic        r_irq;

  logic [23:0] w_live;
  logic        w_stable;
  logic        w_match;
  logic        w_req;
  logic        w_time_rd;
  logic        w_access;
  logic        w_wr_status;
  logic        w_wr_time;
  logic        w_time_ok;
  logic [2:0]  w_status;
  logic        w_unused;

  assign w_live    = {hour_i, min_i, sec_i};
  assign w_stable  = (r_settle == '0) && !tick_i;
  assign w_match   = w_stable && (w_live == r_alarm);
  assign w_req     = wb.cyc_i && wb.stb_i;
  assign w_time_rd = !wb.we_i && (wb.adr_i == ADR_TIME);
  // An access is performed in IDLE unless it is a time read that must wait out the ripple.
  assign w_access    = (r_state == S_IDLE) && w_req && !(w_time_rd && !w_stable);
  assign w_wr_status = w_access && wb.we_i && (wb.adr_i == ADR_STATUS);
  assign w_wr_time   = w_access && wb.we_i && (wb.adr_i == ADR_TIME);
  assign w_time_ok   = bcd_valid(wb.dat_i[7:0],   8'h59) &&
                       bcd_valid(wb.dat_i[15:8],  8'h59) &&
                       bcd_valid(wb.dat_i[23:16], HOUR_MAX);

  assign w_status[ST_PEND] = r_pend;
  assign w_status[ST_WERR] = r_werr;
  assign w_status[ST_AEN]  = r_aen;
  assign w_unused = &{1'b0, wb.dat_i[31:24]};

  assign wb.dat_o   = r_dat;
  assign wb.ack_o   = r_ack;
  assign load_o     = r_load;
  assign load_dat_o = r_load_dat;
  assign irq_o      = r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_settle <= '0;
    end else if (tick_i) begin
      r_settle <= SW'(SETTLE);
    end else if (r_settle != '0) begin
      r_settle <= r_settle - SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_dat       <= '0;
      r_ack       <= 1'b0;
      r_load      <= 1'b0;
      r_load_pend <= 1'b0;
      r_load_dat  <= '0;
      r_alarm     <= '0;
      r_aen       <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_time_rd && !w_stable) begin
              r_state <= S_WAIT_STABLE;
            end else begin
              r_state     <= S_ACK;
              r_dat       <= '0;
              r_load_pend <= 1'b0;
              if (wb.we_i) begin
                case (wb.adr_i)
                  ADR_TIME: begin
                    if (w_time_ok) begin
                      r_load_pend <= 1'b1;
                      r_load_dat  <= wb.dat_i[23:0];
                    end
                  end
                  ADR_ALARM:  r_alarm <= wb.dat_i[23:0];
                  ADR_STATUS: r_aen   <= wb.dat_i[ST_AEN];
                  default: ;
                endcase
              end else begin
                case (wb.adr_i)
                  ADR_TIME:   r_dat <= {8'h00, w_live};
                  ADR_ALARM:  r_dat <= {8'h00, r_alarm};
                  ADR_STATUS: r_dat <= {29'd0, w_status};
                  default: ;
                endcase
              end
            end
          end
        end
        S_WAIT_STABLE: begin
          if (!wb.cyc_i) begin
            r_state <= S_IDLE;
          end else if (w_stable) begin
            r_dat       <= {8'h00, w_live};
            r_load_pend <= 1'b0;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b1;
          r_load  <= r_load_pend;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky status bits: a new event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend       <= 1'b0;
      r_werr       <= 1'b0;
      r_prev_match <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_stable) begin
        r_prev_match <= w_match;
      end
      r_pend <= (r_pend & ~(w_wr_status & wb.dat_i[ST_PEND])) | (w_match & ~r_prev_match);
      r_werr <= (r_werr & ~(w_wr_status & wb.dat_i[ST_WERR])) | (w_wr_time & ~w_time_ok);
      r_irq  <= r_pend & r_aen;
    end
  end

endmodule

// File: doc/rtc_wb_slave.md
Name: rtc_wb_slave

Overview:
- Bus-side reader/writer for the RTC's cascaded BCD time counters (seconds, minutes, hours).
- Presents time, alarm and status registers on a classic Wishbone slave port.
- Returns a ripple-coherent snapshot of the live counters on read and pushes validated set-time loads back to the counters.
- Raises an alarm interrupt on a time match. Sits between the system bus and the RTC counter chain.

Parameters:
- SETTLE, 2, cycles after a seconds tick during which counter outputs are considered rippling (sec->min->hour carry chain)
- HOUR_MAX, 8'h23, largest legal BCD hour value

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  Wishbone write enable
- adr_i  in  2  word address (byte address bits [3:2])
- dat_i  in  32  write data
- dat_o  out  32  read data, valid with ack_o
- ack_o  out  1  Wishbone acknowledge, one-cycle pulse
- sec_i  in  8  live BCD seconds
- min_i  in  8  live BCD minutes
- hour_i  in  8  live BCD hours
- tick_i  in  1  one-cycle pulse, seconds counter advancing this edge
- load_o  out  1  one-cycle load strobe to counters
- load_dat_o  out  24  {hour, min, sec} BCD load value
- irq_o  out  1  alarm interrupt, level

Behaviour:
- Reset (rst_i=1 at clk_i edge): dat_o=0, ack_o=0, load_o=0, load_dat_o=0, irq_o=0, ALARM=0, STATUS=0, FSM=IDLE, settle counter=0. Applies mid-transaction: pending ack is dropped and no load is issued.
- Register map:
  - adr 0 TIME: read {8'h00, hour, min, sec}; write sets time.
  - adr 1 ALARM: RW, bits [23:0], same packing as TIME.
  - adr 2 STATUS:
    - bit0 alarm_pending, W1C
    - bit1 write_err, W1C
    - bit2 alarm_en, RW
  - adr 3: reads 0, writes ignored.
- Settle window: tick_i=1 loads the settle counter with SETTLE. It decrements to 0 each cycle. stable = (counter==0) && !tick_i.
- FSM, states IDLE, WAIT_STABLE, ACK:
  - IDLE: on cyc_i&stb_i, go to WAIT_STABLE if the access is a TIME read and !stable. Otherwise perform the access and go to ACK.
  - WAIT_STABLE: when stable, capture the live time into dat_o and go to ACK. If cyc_i drops, return to IDLE with no ack.
  - ACK: ack_o=1 for exactly one cycle, then IDLE. The master drops stb_i after ack; a held stb_i starts a new access.
- Latency: non-TIME-read access gives ack 2 cycles after strobe sampled. TIME read while stable: 2 cycles. TIME read during the settle window: until stable, plus 2.
- TIME write validation:
  - Each nibble must be <=9.
  - sec<=8'h59, min<=8'h59, hour<=HOUR_MAX.
  - dat_i[31:24] is ignored.
  - Valid: load_o pulses 1 cycle, coincident with ack_o, and load_dat_o=dat_i[23:0].
  - Invalid: no load_o, write_err set. Ack is issued either way.
- ALARM write stores dat_i[23:0] unvalidated; an illegal value never matches.
- Alarm detection:
  - match = stable && {hour_i,min_i,sec_i}==ALARM.
  - alarm_pending is set on a rising edge of match: registered previous-match flag, only updated when stable. It fires once per matching second.
  - irq_o = alarm_pending & alarm_en, registered.
- Simultaneous W1C write and new match in the same cycle: set wins.
- Simultaneous TIME load and tick_i: the load is issued; the counters own priority.

Decomposition:
- Shared package rtc_pkg:
  - register address constants (ADR_TIME=0, ADR_ALARM=1, ADR_STATUS=2)
  - STATUS bit indices
  - FSM state encoding
  - a bcd_valid function (digit<=9 and field<=limit)
- No sub-module needed. Validation is a function; FSM, settle counter and alarm logic stay in one module.

Test Plan:
- Reset then read STATUS -> dat_o=0, ack 2 cycles after strobe, irq_o=0.
- Live 23:59:59, tick_i pulse with counters rippling over SETTLE cycles to 00:00:00; TIME read issued the cycle after tick -> ack delayed until settled, dat_o=32'h00000000, never a mixed value like 32'h00235900.
- Write TIME 32'h00125930 -> load_o single pulse with load_dat_o=24'h125930 on the ack cycle. Write 32'h00126A00 -> no load_o, STATUS.bit1=1; write STATUS 32'h2 -> bit1 cleared.
- ALARM=24'h000005, alarm_en=1, live time steps 00:00:04->05->06 -> alarm_pending and irq_o rise once at 05; write STATUS 32'h5 clears pending, irq_o drops, and the bit does not re-set during 06.
- Assert rst_i while in WAIT_STABLE -> no ack_o, no load_o, all outputs 0 next cycle.
- Write HOUR 8'h24 (32'h00240000) -> rejected, write_err set; write 8'h23 -> accepted.
